rx_lane_scheduler: RTL and testbench
====================================

Name: rx_lane_scheduler

Overview:
- Frame-level round-robin scheduler that merges the per-lane decoded byte streams (output of each lane's channel decoder) into one 64-bit AXI-Stream toward the host side of the receive layer.
- Grants one lane at a time, holds the grant for a whole frame (until tlast), and packs that lane's bytes into 64-bit words.
- Also counts per-frame CRC result events from all lanes and applies a runtime lane-enable mask.

Parameters:
- LANES, 8, number of receive lanes (2, 4 or 8).
- OUT_W, 64, output data width in bits; must equal 8*BPW.
- BPW, 8, bytes per output word.
- CNT_W, 32, width of the saturating event counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- lane_en  in  LANES  lane-enable mask; bit i=1 allows lane i to be granted
- s_axis_input_tvalid  in  1 x LANES (unpacked)  per-lane byte valid
- s_axis_input_tready  out  1 x LANES (unpacked)  per-lane ready
- s_axis_input_tdata  in  8 x LANES (unpacked)  per-lane byte
- s_axis_input_tlast  in  1 x LANES (unpacked)  per-lane end of frame
- event_s_error  in  1 x LANES (unpacked)  1-cycle pulse: lane frame CRC failed
- event_s_right  in  1 x LANES (unpacked)  1-cycle pulse: lane frame CRC passed
- m_axis_output_tvalid  out  1  output word valid
- m_axis_output_tready  in  1  downstream ready
- m_axis_output_tdata  out  OUT_W  packed word; first byte in bits [7:0]
- m_axis_output_tkeep  out  BPW  byte-valid mask (contiguous from bit 0)
- m_axis_output_tlast  out  1  last word of frame
- grant_lane  out  3  currently/last granted lane index
- err_cnt  out  CNT_W  saturating count of error events
- ok_cnt  out  CNT_W  saturating count of right events

Behaviour:
- Reset: all outputs 0; state IDLE; packing register, byte index and counters cleared; rr pointer = LANES-1, so lane 0 has first priority.
- IDLE:
  - Candidates = tvalid[i] & lane_en[i].
  - Choose the first candidate searching from rr_ptr+1 with wrap-around. Latch it into grant_lane and set rr_ptr to that lane. Go to PACK next cycle.
  - No candidate: stay in IDLE.
  - All s_axis_input_tready are 0 in IDLE.
- PACK:
  - tready[grant_lane]=1; all other readies 0.
  - Each accepted byte is written into byte slot idx and idx increments.
  - On the byte that fills slot BPW-1, or on a tlast byte: register tdata/tkeep/tlast, assert m_axis_output_tvalid on the next cycle, and go to OUT.
  - tkeep = (1<<(idx+1))-1. Unused bytes are 0.
- OUT:
  - tready all 0. Word and tvalid are held stable until m_axis_output_tready=1.
  - On handshake: idx=0, tvalid drops next cycle (unless reloaded); go to IDLE if tlast was set, else back to PACK.
- Latency: last byte accepted at cycle n → word visible at n+1. Minimum 9 cycles per full word (8 accept + 1 output).
- Grant changes only in IDLE, so frames from different lanes never interleave.
- Clearing lane_en[grant_lane] mid-frame does not abort the frame; the mask only affects the next arbitration.
- A 1-byte frame produces one word with tkeep=0x01 and tlast=1.
- Counters:
  - Every cycle, add popcount(event_s_error) to err_cnt and popcount(event_s_right) to ok_cnt.
  - Events count on every lane regardless of lane_en or grant; simultaneous pulses are all counted.
  - Each counter saturates at all-ones and never wraps.
- Reset asserted mid-frame: all state is discarded immediately. The partial word is lost and tvalid=0 the next cycle. Upstream bytes of the interrupted frame are re-arbitrated as a new frame; discarding them is upstream's responsibility.

Decomposition:
- Shared package (existing receive-layer parameter include): LANES default, byte/word widths, the state enum {IDLE, PACK, OUT}, and a popcount function.
- One natural sub-module: rr_arbiter (LANES-wide request vector + pointer → one-hot grant + index + any_req), purely combinational, reusable by the transmit-side distributor.

Test Plan:
- Lane 0 alone, 16-byte frame 0x01..0x10, tready=1 → two words: 0x0807060504030201 tkeep=0xFF tlast=0, then 0x100F0E0D0C0B0A09 tkeep=0xFF tlast=1; grant_lane=0.
- Lanes 2 and 5 both present 3-byte frames (A0..A2, B0..B2) at the same time after reset → lane 2 first (tdata=0x0000000000A2A1A0, tkeep=0x07, tlast=1), then lane 5; no interleave.
- Lanes 0,1,2 each send 4 frames of 1 byte → grant order 0,1,2,0,1,2,…; every word has tkeep=0x01 and tlast=1.
- lane_en=8'b1111_1110 with lane 0 and lane 3 valid → only lane 3 is granted; lane 0 tready stays 0.
- Hold m_axis_output_tready=0 for 20 cycles during a frame → word and tvalid stay stable, upstream tready=0, no byte lost; output resumes when ready returns.
- event_s_error pulsed on lanes 1, 4, 7 in the same cycle → err_cnt increments by 3. Preload near saturation by driving 2^CNT_W events (or use CNT_W=4: 20 events → err_cnt=15).

Source files
------------

// File: rtl/rx_lane_scheduler_pkg.sv
// rx_lane_scheduler_pkg: shared receive-layer parameters, scheduler states and helpers
package rx_lane_scheduler_pkg;
  localparam int LANES_DEF = 8;
  localparam int BYTE_W = 8;
  localparam int BPW_DEF = 8;
  localparam int OUT_W_DEF = BYTE_W * BPW_DEF;
  typedef enum logic [1:0] {IDLE, PACK, OUT} state_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount = popcount + 4'(v[i]);
  endfunction
endpackage

// File: rtl/rx_lane_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr, with wrap-around
module rr_arbiter #(
  parameter int N = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_req
);
  always_comb begin
    idx = '0;
    any_req = |req;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    gnt = any_req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/rx_lane_scheduler.sv
// rx_lane_scheduler: frame-level round-robin merge of per-lane byte streams into 64-bit words
module rx_lane_scheduler
  import rx_lane_scheduler_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int BPW = BPW_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] lane_en,
  input  logic             s_axis_input_tvalid [LANES],
  output logic             s_axis_input_tready [LANES],
  input  logic [7:0]       s_axis_input_tdata [LANES],
  input  logic             s_axis_input_tlast [LANES],
  input  logic             event_s_error [LANES],
  input  logic             event_s_right [LANES],
  output logic             m_axis_output_tvalid,
  input  logic             m_axis_output_tready,
  output logic [OUT_W-1:0] m_axis_output_tdata,
  output logic [BPW-1:0]   m_axis_output_tkeep,
  output logic             m_axis_output_tlast,
  output logic [2:0]       grant_lane,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ok_cnt
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int XW = (BPW > 1) ? $clog2(BPW) : 1;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, gsel, arb_idx;
  logic [LANES-1:0] req, arb_gnt, gnt_oh;
  logic [XW-1:0] idx;
  logic any_req, byte_hs, cur_last, word_end;
  logic [7:0] ev_err, ev_ok;
  logic [CNT_W:0] err_sum, ok_sum;
  rr_arbiter #(.N(LANES)) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any_req(any_req)
  );
  always_comb begin
    req = '0;
    ev_err = '0;
    ev_ok = '0;
    for (int i = 0; i < LANES; i++) begin
      req[i] = s_axis_input_tvalid[i] & lane_en[i];
      ev_err[i] = event_s_error[i];
      ev_ok[i] = event_s_right[i];
      s_axis_input_tready[i] = (state == PACK) && gnt_oh[i];
    end
    byte_hs = (state == PACK) && s_axis_input_tvalid[gsel];
    cur_last = s_axis_input_tlast[gsel];
    word_end = byte_hs && (idx == XW'(BPW - 1) || cur_last);
    err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(popcount(ev_err));
    ok_sum = {1'b0, ok_cnt} + (CNT_W + 1)'(popcount(ev_ok));
    state_nx = state == IDLE ? (any_req ? PACK : IDLE) :
               state == PACK ? (word_end ? OUT : PACK) :
               (m_axis_output_tready ? (m_axis_output_tlast ? IDLE : PACK) : OUT);
  end
  assign grant_lane = 3'(gsel);
  // The output register doubles as the packing register: tvalid is low while bytes accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= IW'(LANES - 1);
      gsel <= '0;
      gnt_oh <= '0;
      idx <= '0;
      m_axis_output_tdata <= '0;
      m_axis_output_tkeep <= '0;
      m_axis_output_tlast <= 1'b0;
      m_axis_output_tvalid <= 1'b0;
      err_cnt <= '0;
      ok_cnt <= '0;
    end else begin
      state <= state_nx;
      err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      ok_cnt <= ok_sum[CNT_W] ? '1 : ok_sum[CNT_W-1:0];
      if (state == IDLE && any_req) begin
        gsel <= arb_idx;
        rr_ptr <= arb_idx;
        gnt_oh <= arb_gnt;
      end
      if (byte_hs) begin
        m_axis_output_tdata[int'(idx)*8 +: 8] <= s_axis_input_tdata[gsel];
        idx <= idx + 1'b1;
      end
      if (word_end) begin
        m_axis_output_tkeep <= {BPW{1'b1}} >> (BPW - 1 - int'(idx));
        m_axis_output_tlast <= cur_last;
        m_axis_output_tvalid <= 1'b1;
      end
      if (state == OUT && m_axis_output_tready) begin
        idx <= '0;
        m_axis_output_tdata <= '0;
        m_axis_output_tkeep <= '0;
        m_axis_output_tlast <= 1'b0;
        m_axis_output_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rx_lane_scheduler.sv
// tb_rx_lane_scheduler: directed tables, corner sequences and randomized traffic vs a frame-level model
module tb_rx_lane_scheduler;
  localparam int LANES = 8;
  localparam int BPW = 8;
  localparam int OUT_W = 64;
  localparam int CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [LANES-1:0] lane_en = '1;
  logic tv [LANES];
  logic tr [LANES];
  logic [7:0] td [LANES];
  logic tl [LANES];
  logic ee [LANES];
  logic er [LANES];
  logic m_tvalid, m_tready, m_tlast;
  logic [OUT_W-1:0] m_tdata;
  logic [BPW-1:0] m_tkeep;
  logic [2:0] grant_lane;
  logic [CNT_W-1:0] err_cnt, ok_cnt;
  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  logic tr0_seen = 1'b0;
  typedef struct {int lane; logic [63:0] d; logic [7:0] k; logic l;} word_t;
  typedef struct {int lane; int len; logic [7:0] base; int grp;} frame_t;
  typedef struct {int grp; word_t w;} vec_t;
  word_t exp_q[$];
  logic [8:0] lane_q [LANES][$];
  frame_t frames [3];
  vec_t vecs [4];

  rx_lane_scheduler #(.LANES(LANES), .OUT_W(OUT_W), .BPW(BPW), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .lane_en(lane_en),
    .s_axis_input_tvalid(tv),
    .s_axis_input_tready(tr),
    .s_axis_input_tdata(td),
    .s_axis_input_tlast(tl),
    .event_s_error(ee),
    .event_s_right(er),
    .m_axis_output_tvalid(m_tvalid),
    .m_axis_output_tready(m_tready),
    .m_axis_output_tdata(m_tdata),
    .m_axis_output_tkeep(m_tkeep),
    .m_axis_output_tlast(m_tlast),
    .grant_lane(grant_lane),
    .err_cnt(err_cnt),
    .ok_cnt(ok_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic any_tr();
    logic a = 1'b0;
    for (int i = 0; i < LANES; i++) a |= tr[i];
    return a;
  endfunction

  task automatic drive();
    for (int i = 0; i < LANES; i++) begin
      tv[i] = lane_q[i].size() > 0;
      td[i] = tv[i] ? lane_q[i][0][7:0] : 8'h00;
      tl[i] = tv[i] ? lane_q[i][0][8] : 1'b0;
    end
    m_tready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // One clock: inputs set after a negedge, handshakes judged before the posedge, then on to the next negedge.
  task automatic tick();
    logic pop [LANES];
    word_t w;
    drive();
    #1;
    for (int i = 0; i < LANES; i++) pop[i] = tv[i] && tr[i] && !reset;
    if (tr[0]) tr0_seen = 1'b1;
    if (m_tvalid && m_tready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_word actual=%h required=none", m_tdata);
      end else begin
        w = exp_q.pop_front();
        check("word_data", m_tdata, w.d);
        check("word_keep", 64'(m_tkeep), 64'(w.k));
        check("word_last", 64'(m_tlast), 64'(w.l));
        check("word_lane", 64'(grant_lane), 64'(w.lane));
      end
    end
    @(posedge clk);
    for (int i = 0; i < LANES; i++) if (pop[i]) void'(lane_q[i].pop_front());
    @(negedge clk);
  endtask

  task automatic clear_q();
    for (int i = 0; i < LANES; i++) lane_q[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    clear_q();
    reset = 1'b1;
    repeat (2) begin
      drive();
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic push_frame(input int lane, input int len, input logic [7:0] base, input logic rnd);
    for (int j = 0; j < len; j++)
      lane_q[lane].push_back({j == len - 1 ? 1'b1 : 1'b0, rnd ? 8'($urandom) : 8'(int'(base) + j)});
  endtask

  // Frame-level reference: round-robin over lanes with whole frames queued, each frame cut into 8-byte words.
  task automatic model(input logic [LANES-1:0] en);
    int pos [LANES];
    int rr = LANES - 1;
    int pick, n;
    logic [63:0] d;
    logic done;
    logic [8:0] b;
    foreach (pos[i]) pos[i] = 0;
    forever begin
      pick = -1;
      for (int k = 1; k <= LANES && pick < 0; k++) begin
        int l = (rr + k) % LANES;
        if (en[l] && pos[l] < lane_q[l].size()) pick = l;
      end
      if (pick < 0) break;
      rr = pick;
      d = '0;
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = lane_q[pick][pos[pick]];
        pos[pick]++;
        d[8*n +: 8] = b[7:0];
        n++;
        done = b[8];
        if (n == BPW || done) begin
          exp_q.push_back('{pick, d, 8'((1 << n) - 1), done});
          d = '0;
          n = 0;
        end
      end
    end
  endtask

  task automatic run(input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL run_timeout pending_words=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    int err_m, ok_m, n;
    logic [7:0] re, ro;
    frames[0] = '{0, 16, 8'h01, 0};
    frames[1] = '{2, 3, 8'hA0, 1};
    frames[2] = '{5, 3, 8'hB0, 1};
    vecs[0] = '{0, '{0, 64'h0807060504030201, 8'hFF, 1'b0}};
    vecs[1] = '{0, '{0, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b1}};
    vecs[2] = '{1, '{2, 64'h0000000000A2A1A0, 8'h07, 1'b1}};
    vecs[3] = '{1, '{5, 64'h0000000000B2B1B0, 8'h07, 1'b1}};
    for (int i = 0; i < LANES; i++) begin
      ee[i] = 1'b0;
      er[i] = 1'b0;
    end
    do_reset();
    check("rst_tvalid", 64'(m_tvalid), 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tkeep", 64'(m_tkeep), 0);
    check("rst_tlast", 64'(m_tlast), 0);
    check("rst_grant", 64'(grant_lane), 0);
    check("rst_err", 64'(err_cnt), 0);
    check("rst_ok", 64'(ok_cnt), 0);
    check("rst_tready", 64'(any_tr()), 0);
    for (int g = 0; g < 2; g++) begin
      do_reset();
      foreach (frames[f]) if (frames[f].grp == g) push_frame(frames[f].lane, frames[f].len, frames[f].base, 1'b0);
      foreach (vecs[v]) if (vecs[v].grp == g) exp_q.push_back(vecs[v].w);
      run(200);
    end
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int l = 0; l < 3; l++) push_frame(l, 1, 8'(16 * l + f), 1'b0);
    model(lane_en);
    run(300);
    lane_en = 8'b1111_1110;
    do_reset();
    tr0_seen = 1'b0;
    push_frame(0, 2, 8'h10, 1'b0);
    push_frame(3, 2, 8'h30, 1'b0);
    exp_q.push_back('{3, 64'h3130, 8'h03, 1'b1});
    run(100);
    repeat (5) tick();
    check("mask_tready0", 64'(tr0_seen), 0);
    check("mask_lane0_left", 64'(lane_q[0].size()), 2);
    lane_en = '1;
    do_reset();
    push_frame(3, 16, 8'h40, 1'b0);
    model(lane_en);
    ready_mode = 2;
    n = 0;
    while (!m_tvalid && n < 40) begin
      tick();
      n++;
    end
    check("stall_reach", 64'(m_tvalid), 1);
    repeat (20) begin
      tick();
      check("stall_tvalid", 64'(m_tvalid), 1);
      check("stall_tdata", m_tdata, exp_q[0].d);
      check("stall_tready", 64'(any_tr()), 0);
      check("stall_left", 64'(lane_q[3].size()), 8);
    end
    ready_mode = 0;
    run(100);
    do_reset();
    push_frame(1, 6, 8'h60, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("midrst_tvalid", 64'(m_tvalid), 0);
    check("midrst_tready", 64'(any_tr()), 0);
    reset = 1'b0;
    check("midrst_left", 64'(lane_q[1].size()), 3);
    model(lane_en);
    run(100);
    for (int r = 0; r < 4; r++) begin
      lane_en = 8'($urandom_range(1, 255));
      do_reset();
      for (int l = 0; l < LANES; l++)
        repeat ($urandom_range(0, 3)) push_frame(l, $urandom_range(1, 20), 8'h00, 1'b1);
      model(lane_en);
      ready_mode = 1;
      run(4000);
      ready_mode = 0;
    end
    lane_en = '1;
    do_reset();
    ee[1] = 1'b1;
    ee[4] = 1'b1;
    ee[7] = 1'b1;
    er[0] = 1'b1;
    er[2] = 1'b1;
    tick();
    for (int i = 0; i < LANES; i++) begin
      ee[i] = 1'b0;
      er[i] = 1'b0;
    end
    check("evt_err3", 64'(err_cnt), 3);
    check("evt_ok2", 64'(ok_cnt), 2);
    err_m = 3;
    ok_m = 2;
    repeat (12) begin
      re = 8'($urandom);
      ro = 8'($urandom);
      for (int i = 0; i < LANES; i++) begin
        ee[i] = re[i];
        er[i] = ro[i];
      end
      tick();
      err_m = (err_m + $countones(re) > SAT) ? SAT : err_m + $countones(re);
      ok_m = (ok_m + $countones(ro) > SAT) ? SAT : ok_m + $countones(ro);
      check("evt_err_rand", 64'(err_cnt), 64'(err_m));
      check("evt_ok_rand", 64'(ok_cnt), 64'(ok_m));
    end
    for (int i = 0; i < LANES; i++) ee[i] = 1'b1;
    repeat (3) tick();
    check("evt_err_sat", 64'(err_cnt), 64'(SAT));
    for (int i = 0; i < LANES; i++) ee[i] = 1'b0;
    tick();
    check("evt_err_hold", 64'(err_cnt), 64'(SAT));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
